// File: rtl/tx_gmii_serializer.sv
// GMII transmit serializer: drains TX frame FIFO words onto GMII one byte per clock,
// adding preamble/SFD, zero pad to minimum size, FCS and inter-frame gap.
module tx_gmii_serializer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        FIFO_RD_ENA,
    input  logic [31:0] FIFO_RD_DATA,
    input  logic        FIFO_RD_EMPTY,
    output logic [7:0]  GMII_TXD,
    output logic        GMII_TX_EN,
    output logic        GMII_TX_ER,
    output logic        TX_BUSY,
    output logic        TX_DONE,
    output logic        TX_UNDERRUN
);

    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam int IW = $clog2(IFG_BYTES + 1);
    localparam logic [10:0] MINF = 11'(MIN_FRAME);

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DISCARD
    } state_t;

    state_t      state;
    logic [10:0] len;
    logic [10:0] idx;
    logic [9:0]  wcnt;
    logic [PW-1:0] pcnt;
    logic [IW-1:0] icnt;
    logic [2:0]  fcnt;
    logic [31:0] crc;

    logic        fetch;
    logic        under;
    logic        pop_data;
    logic [7:0]  head_byte;
    logic [31:0] crc_base;
    logic [31:0] crc_in;
    logic [11:0] hdr_sum;
    logic [9:0]  hdr_words;

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // State names the byte currently on the wire; the next byte is
    // fetched from the FIFO head in the cycle before it is driven.
    always_comb begin
        fetch     = (state == SFD || state == DATA || state == PAD) && (idx < len);
        under     = fetch && (idx[1:0] == 2'd0) && FIFO_RD_EMPTY;
        pop_data  = fetch && !under &&
                    ((idx[1:0] == 2'd3) || (idx == len - 11'd1));
        head_byte = FIFO_RD_DATA[{idx[1:0], 3'b000} +: 8];
        crc_base  = (state == SFD) ? 32'hFFFFFFFF : crc;
        crc_in    = crc_upd(crc_base, fetch ? head_byte : 8'h00);
        hdr_sum   = {1'b0, FIFO_RD_DATA[10:0]} + 12'd3;
        hdr_words = hdr_sum[11:2];
    end

    always_comb begin
        FIFO_RD_ENA = 1'b0;
        if (!RST) begin
            case (state)
                IDLE:    FIFO_RD_ENA = !FIFO_RD_EMPTY;
                DISCARD: FIFO_RD_ENA = (wcnt != 10'd0) && !FIFO_RD_EMPTY;
                default: FIFO_RD_ENA = pop_data;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            GMII_TXD    <= 8'h00;
            GMII_TX_EN  <= 1'b0;
            GMII_TX_ER  <= 1'b0;
            TX_BUSY     <= 1'b0;
            TX_DONE     <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            len         <= '0;
            idx         <= '0;
            wcnt        <= '0;
            pcnt        <= '0;
            icnt        <= '0;
            fcnt        <= '0;
            crc         <= '1;
        end else begin
            TX_DONE     <= 1'b0;
            TX_UNDERRUN <= 1'b0;
            GMII_TX_ER  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!FIFO_RD_EMPTY) begin
                        len  <= FIFO_RD_DATA[10:0];
                        wcnt <= hdr_words;
                        idx  <= '0;
                        if (FIFO_RD_DATA[10:0] != 11'd0) begin
                            state      <= PRE;
                            pcnt       <= PW'(1);
                            GMII_TXD   <= 8'h55;
                            GMII_TX_EN <= 1'b1;
                            TX_BUSY    <= 1'b1;
                        end
                    end
                end
                PRE: begin
                    if (pcnt < PW'(PREAMBLE_LEN)) begin
                        pcnt     <= pcnt + PW'(1);
                        GMII_TXD <= 8'h55;
                    end else begin
                        GMII_TXD <= 8'hD5;
                        state    <= SFD;
                    end
                end
                SFD, DATA, PAD: begin
                    if (under) begin
                        GMII_TXD    <= 8'h00;
                        GMII_TX_ER  <= 1'b1;
                        TX_UNDERRUN <= 1'b1;
                        state       <= DISCARD;
                    end else if (fetch) begin
                        GMII_TXD <= head_byte;
                        crc      <= crc_in;
                        idx      <= idx + 11'd1;
                        state    <= DATA;
                        if (pop_data)
                            wcnt <= wcnt - 10'd1;
                    end else if (idx < MINF) begin
                        GMII_TXD <= 8'h00;
                        crc      <= crc_in;
                        idx      <= idx + 11'd1;
                        state    <= PAD;
                    end else begin
                        GMII_TXD <= ~crc[7:0];
                        fcnt     <= 3'd1;
                        state    <= FCS;
                    end
                end
                FCS: begin
                    if (fcnt == 3'd4) begin
                        GMII_TXD   <= 8'h00;
                        GMII_TX_EN <= 1'b0;
                        icnt       <= IW'(1);
                        state      <= IFG;
                    end else begin
                        GMII_TXD <= ~crc[{fcnt[1:0], 3'b000} +: 8];
                        fcnt     <= fcnt + 3'd1;
                        if (fcnt == 3'd3)
                            TX_DONE <= 1'b1;
                    end
                end
                DISCARD: begin
                    GMII_TXD   <= 8'h00;
                    GMII_TX_EN <= 1'b0;
                    if (wcnt == 10'd0) begin
                        icnt  <= IW'(1);
                        state <= IFG;
                    end else if (!FIFO_RD_EMPTY) begin
                        wcnt <= wcnt - 10'd1;
                    end
                end
                IFG: begin
                    if (icnt == IW'(IFG_BYTES)) begin
                        state   <= IDLE;
                        TX_BUSY <= 1'b0;
                    end else begin
                        icnt <= icnt + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_gmii_serializer.md
# tx_gmii_serializer

Transmit-side consumer of the MAC's TX frame FIFO: pops 32-bit frame words from the FIFO read port and serialises them onto the GMII transmit interface, one byte per clock. Adds preamble, SFD, zero padding to minimum frame size, IEEE 802.3 FCS and inter-frame gap. It is the read-side partner of the host-facing FIFO writer. It runs entirely in the 125 MHz GMII TX clock domain, and the FIFO's read clock is tied to the same clock.

## Interface
Parameters:
- PREAMBLE_LEN, 7: number of 0x55 bytes before SFD.
- MIN_FRAME, 60: minimum data+pad byte count, excluding FCS.
- IFG_BYTES, 12: idle cycles after the last FCS byte.

Ports:
- CLK  in  1  GMII TX clock. The FIFO read clock is driven by the same clock.
- RST  in  1  reset, synchronous, active-high.
- FIFO_RD_ENA  out  1  pops the current FIFO word.
- FIFO_RD_DATA  in  32  current FIFO head word, valid whenever FIFO_RD_EMPTY=0 (show-ahead).
- FIFO_RD_EMPTY  in  1  FIFO has no word.
- GMII_TXD  out  8  transmit byte.
- GMII_TX_EN  out  1  transmit enable.
- GMII_TX_ER  out  1  transmit error.
- TX_BUSY  out  1  high in every state except IDLE.
- TX_DONE  out  1  one-cycle pulse when a frame completes normally (last FCS byte cycle).
- TX_UNDERRUN  out  1  one-cycle pulse when a frame is aborted.

## Operation
Frame format in the FIFO:
- Header word: [10:0] is byte length L of data, without FCS; [31:11] are ignored.
- The header is followed by ceil(L/4) data words.
- Data words are little-endian: byte 0 is [7:0], byte 3 is [31:24].
- Unused bytes of the last word are ignored.

States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DISCARD.
- IDLE: when FIFO_RD_EMPTY=0, pop the header and latch L.
  - L=0: stay in IDLE; no frame is sent.
  - Otherwise, go to PRE.
- PRE: TXD=0x55 for PREAMBLE_LEN cycles, then SFD.
- SFD: TXD=0xD5 for one cycle, then DATA.
- DATA: send byte (idx mod 4) of the head word.
  - Pop the word when its byte 3 is sent, or when byte L-1 is sent.
  - After byte L-1: go to PAD if L<MIN_FRAME, else go to FCS.
- PAD: TXD=0x00 until MIN_FRAME bytes have been sent in total, then FCS.
- FCS: 4 cycles, sending ~CRC[7:0], ~CRC[15:8], ~CRC[23:16], ~CRC[31:24], then IFG.
- IFG: TX_EN=0 for IFG_BYTES cycles, then IDLE. No FIFO pop is allowed in IFG.
- Underrun: in DATA, if FIFO_RD_EMPTY=1 at a byte-0 slot of a word:
  - that cycle drives TX_EN=1, TX_ER=1, TXD=0x00 and pulses TX_UNDERRUN;
  - the state goes to DISCARD.
- DISCARD: TX_EN=0. Pop the remaining words of the frame whenever the FIFO is non-empty, then go to IFG.
- CRC:
  - Reflected polynomial 0xEDB88320, processed LSB-first per byte.
  - CRC is initialised to 0xFFFFFFFF in SFD.
  - CRC is updated over every DATA and PAD byte.
- Counters:
  - Byte counter is 11 bits; no wrap is possible since L≤2047.
  - PRE and IFG counters are sized from their parameters.
- RST: when asserted in any state, the next cycle is IDLE with all outputs at reset values. Any partial frame in the FIFO is not drained; flushing it is the system's responsibility.

## Timing
- Reset values: FIFO_RD_ENA=0, GMII_TXD=0x00, GMII_TX_EN=0, GMII_TX_ER=0, TX_BUSY=0, TX_DONE=0, TX_UNDERRUN=0.
- All GMII outputs and pulses are registered.
- FIFO_RD_ENA is combinational from state, counters and FIFO_RD_EMPTY. It is high for exactly one cycle per consumed word.
- Latency: header pop in IDLE at cycle N → TX_EN=1 with the first 0x55 at cycle N+1.
- Wire length of one frame is 8 + max(L,MIN_FRAME) + 4 cycles of TX_EN=1, followed by IFG_BYTES cycles of TX_EN=0.
- Back-to-back frames: the next header may be popped in the first IDLE cycle after IFG. The minimum gap between frames is IFG_BYTES+1 cycles with TX_EN=0.
- TX_DONE is asserted in the same cycle as the last FCS byte.

## Test plan
- Reset check: RST=1 mid-DATA → next cycle all outputs at reset values and TX_BUSY=0.
- 9-byte frame: header L=9, data "123456789" → 0x55×7, 0xD5, then bytes 31..39, then 51 bytes of 0x00, then FCS over 60 bytes matching a reference model; TX_EN high for 72 cycles.
- 64-byte frame (L=60, exactly minimum): no PAD state is entered. FCS matches the model, TX_DONE pulses once, and exactly 16 FIFO pops occur (header + 15 data words).
- Back-to-back frames with L=61 and L=1514 preloaded: exactly 12 TX_EN=0 cycles between the last FCS byte of frame 1 and the preamble of frame 2 (13 including the header IDLE cycle). Both FCS values are correct.
- Underrun: L=100 with only 10 data words available → byte 40 slot shows TX_EN=1, TX_ER=1; TX_UNDERRUN pulses; then 15 more words are popped as they arrive, followed by 12 IFG cycles and IDLE.
- Header L=0 → popped and discarded, TX_EN stays 0, and the next frame starts normally.
